// File: rtl/d1_issue_buffer.sv
// d1_issue_buffer: buffers F2 fetches and issues them into D2, tracking branch delay slots.
// Build option XUM_D1_SKID_EN: 2-entry skid buffer that decouples F2_Ready from D2_Stall (default 1 entry).
`default_nettype none

module d1_issue_buffer (
    input  logic        clock,
    input  logic        reset,
    input  logic        F2_Valid,
    output logic        F2_Ready,
    input  logic [31:0] F2_Instruction,
    input  logic [31:0] F2_FetchPC,
    input  logic        F2_Exception,
    input  logic [4:0]  F2_ExcCode,
    input  logic        F2_IsBranch,
    input  logic        D2_Stall,
    input  logic        D2_Flush,
    output logic        D1_Issued,
    output logic [31:0] D1_Instruction,
    output logic [31:0] D1_FetchPC,
    output logic        D1_Exception,
    output logic [4:0]  D1_ExcCode,
    output logic        D1_IsBDS,
    output logic        D1_F2IsBDS,
    output logic [1:0]  D1_Count
);

`ifdef XUM_D1_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        exc;
        logic [4:0]  exccode;
        logic        isbranch;
    } entry_t;

    // Storage spans the full 1-bit pointer range; DEPTH only governs wrap, so the 1-entry build never touches slot 1.
    entry_t      mem_q [2];
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  count_q, count_d;
    logic        br_pend_q, br_pend_d;

    entry_t      head;
    logic        has_data;
    logic        push;
    logic        pop;

    function automatic logic ptr_inc(input logic p);
        return (DEPTH == 2) ? ~p : 1'b0;
    endfunction

    assign head     = mem_q[rd_ptr_q];
    assign has_data = reset & (count_q != 2'd0);
    assign pop      = has_data & ~D2_Stall & ~D2_Flush;

`ifdef XUM_D1_SKID_EN
    assign F2_Ready = reset & (count_q < 2'd2);
`else
    assign F2_Ready = reset & ((count_q == 2'd0) | pop);
`endif

    assign push = F2_Valid & F2_Ready;

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        br_pend_d = br_pend_q;
        if (D2_Flush) begin
            rd_ptr_d  = 1'b0;
            wr_ptr_d  = 1'b0;
            count_d   = 2'd0;
            br_pend_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            // Each issue either arms the delay-slot flag (branch) or consumes it.
            if (pop) begin
                rd_ptr_d  = ptr_inc(rd_ptr_q);
                br_pend_d = head.isbranch;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            br_pend_q <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            br_pend_q <= br_pend_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{
                instr:    F2_Exception ? 32'h0 : F2_Instruction,
                pc:       F2_FetchPC,
                exc:      F2_Exception,
                exccode:  F2_ExcCode,
                isbranch: F2_IsBranch
            };
        end
    end

    assign D1_Issued      = pop;
    assign D1_Instruction = has_data ? head.instr   : 32'h0;
    assign D1_FetchPC     = has_data ? head.pc      : 32'h0;
    assign D1_Exception   = has_data & head.exc;
    assign D1_ExcCode     = has_data ? head.exccode : 5'h0;
    assign D1_IsBDS       = has_data & br_pend_q;
    assign D1_F2IsBDS     = reset & br_pend_q;
    assign D1_Count       = reset ? count_q : 2'd0;

endmodule

`default_nettype wire

// File: tb/tb_d1_issue_buffer.sv
// Directed and randomized bench for d1_issue_buffer against a queue-based model.
`default_nettype none

module tb_d1_issue_buffer;

`ifdef XUM_D1_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif
    localparam logic [31:0] CAP = SKID ? 32'd2 : 32'd1;

    logic        clock;
    logic        reset;
    logic        F2_Valid;
    logic        F2_Ready;
    logic [31:0] F2_Instruction;
    logic [31:0] F2_FetchPC;
    logic        F2_Exception;
    logic [4:0]  F2_ExcCode;
    logic        F2_IsBranch;
    logic        D2_Stall;
    logic        D2_Flush;
    logic        D1_Issued;
    logic [31:0] D1_Instruction;
    logic [31:0] D1_FetchPC;
    logic        D1_Exception;
    logic [4:0]  D1_ExcCode;
    logic        D1_IsBDS;
    logic        D1_F2IsBDS;
    logic [1:0]  D1_Count;

    d1_issue_buffer dut (
        .clock          (clock),
        .reset          (reset),
        .F2_Valid       (F2_Valid),
        .F2_Ready       (F2_Ready),
        .F2_Instruction (F2_Instruction),
        .F2_FetchPC     (F2_FetchPC),
        .F2_Exception   (F2_Exception),
        .F2_ExcCode     (F2_ExcCode),
        .F2_IsBranch    (F2_IsBranch),
        .D2_Stall       (D2_Stall),
        .D2_Flush       (D2_Flush),
        .D1_Issued      (D1_Issued),
        .D1_Instruction (D1_Instruction),
        .D1_FetchPC     (D1_FetchPC),
        .D1_Exception   (D1_Exception),
        .D1_ExcCode     (D1_ExcCode),
        .D1_IsBDS       (D1_IsBDS),
        .D1_F2IsBDS     (D1_F2IsBDS),
        .D1_Count       (D1_Count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        exc;
        logic [4:0]  code;
        logic        br;
    } ent_t;

    ent_t q[$];
    bit   brp;
    bit   m_push;
    bit   m_iss;
    int   total;
    int   bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic e, input logic [4:0] c, input logic b,
                       input logic st, input logic fl);
        F2_Valid       = v;
        F2_FetchPC     = pc;
        F2_Instruction = ins;
        F2_Exception   = e;
        F2_ExcCode     = c;
        F2_IsBranch    = b;
        D2_Stall       = st;
        D2_Flush       = fl;
        #1;
    endtask

    // Compare every output with the model, then advance the model across one clock edge.
    task automatic cycle();
        int   sz;
        bit   hasd;
        bit   erdy;
        ent_t h;
        ent_t n;
        sz   = q.size();
        hasd = reset && (sz > 0);
        m_iss = hasd && !D2_Stall && !D2_Flush;
        erdy  = reset && (SKID ? (sz < 2) : ((sz == 0) || m_iss));
        m_push = F2_Valid && erdy;
        h = '{32'h0, 32'h0, 1'b0, 5'h0, 1'b0};
        if (hasd) h = q[0];
        chk("ready",   {31'h0, F2_Ready},     {31'h0, erdy});
        chk("issued",  {31'h0, D1_Issued},    {31'h0, m_iss});
        chk("instr",   D1_Instruction,        h.instr);
        chk("pc",      D1_FetchPC,            h.pc);
        chk("exc",     {31'h0, D1_Exception}, {31'h0, h.exc});
        chk("exccode", {27'h0, D1_ExcCode},   {27'h0, h.code});
        chk("isbds",   {31'h0, D1_IsBDS},     {31'h0, hasd && brp});
        chk("f2isbds", {31'h0, D1_F2IsBDS},   {31'h0, reset && brp});
        chk("count",   {30'h0, D1_Count},     reset ? 32'(sz) : 32'd0);
        @(posedge clock);
        if (!reset || D2_Flush) begin
            q.delete();
            brp = 1'b0;
        end else begin
            if (m_iss) begin
                brp = q[0].br;
                void'(q.pop_front());
            end
            if (m_push) begin
                n.instr = F2_Exception ? 32'h0 : F2_Instruction;
                n.pc    = F2_FetchPC;
                n.exc   = F2_Exception;
                n.code  = F2_ExcCode;
                n.br    = F2_IsBranch;
                q.push_back(n);
            end
        end
        #1;
    endtask

    int          idx;
    int          gc;
    int          first_k;
    int          last_k;
    logic [31:0] got [3];
    bit          rv;
    logic [31:0] rpc;
    logic [31:0] rpc_next;
    logic [31:0] rins;
    logic        re;
    logic [4:0]  rc;
    logic        rb;

    initial begin
        total = 0;
        bad   = 0;
        brp   = 1'b0;
        reset = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0);

        // reset
        cycle();
        cycle();
        chk("rst_ready", {31'h0, F2_Ready}, 32'd0);
        reset = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();

        // stream with no stall
        drv(1, 32'h100, 32'h11, 0, 0, 0, 0, 0);
        chk("strm_rdy", {31'h0, F2_Ready}, 32'd1);
        cycle();
        drv(1, 32'h104, 32'h12, 0, 0, 0, 0, 0);
        chk("strm_pc0", D1_FetchPC, 32'h100);
        cycle();
        drv(1, 32'h108, 32'h13, 0, 0, 0, 0, 0);
        chk("strm_pc1", D1_FetchPC, 32'h104);
        chk("strm_cnt1", {30'h0, D1_Count}, 32'd1);
        cycle();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        chk("strm_pc2", D1_FetchPC, 32'h108);
        chk("strm_iss2", {31'h0, D1_Issued}, 32'd1);
        cycle();
        cycle();

        // branch then delay slot
        drv(1, 32'h200, 32'h1000_0001, 0, 0, 1, 0, 0);
        cycle();
        drv(1, 32'h204, 32'h22, 0, 0, 0, 0, 0);
        chk("br_isbds0", {31'h0, D1_IsBDS}, 32'd0);
        cycle();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        chk("bds_pc", D1_FetchPC, 32'h204);
        chk("bds_isbds", {31'h0, D1_IsBDS}, 32'd1);
        chk("bds_f2isbds", {31'h0, D1_F2IsBDS}, 32'd1);
        cycle();
        chk("bds_clear", {31'h0, D1_F2IsBDS}, 32'd0);
        cycle();

        // stall fill, F2 holds refused words
        idx = 0;
        for (int k = 0; k < 4; k++) begin
            drv(idx < 3, 32'h300 + 32'(4 * idx), 32'h30 + 32'(idx), 0, 0, 0, 1, 0);
            cycle();
            if (m_push) idx++;
        end
        drv(idx < 3, 32'h300 + 32'(4 * idx), 32'h30 + 32'(idx), 0, 0, 0, 1, 0);
        chk("fill_count", {30'h0, D1_Count}, CAP);
        chk("fill_ready", {31'h0, F2_Ready}, 32'd0);
        gc = 0;
        first_k = -1;
        last_k = -1;
        for (int i = 0; i < 3; i++) got[i] = 32'h0;
        for (int k = 0; k < 8; k++) begin
            drv(idx < 3, 32'h300 + 32'(4 * idx), 32'h30 + 32'(idx), 0, 0, 0, 0, 0);
            if (D1_Issued === 1'b1 && gc < 3) begin
                got[gc] = D1_FetchPC;
                if (gc == 0) first_k = k;
                last_k = k;
                gc++;
            end
            cycle();
            if (m_push) idx++;
        end
        chk("fill_n", 32'(gc), 32'd3);
        chk("fill_o0", got[0], 32'h300);
        chk("fill_o1", got[1], 32'h304);
        chk("fill_o2", got[2], 32'h308);
        chk("fill_consec", 32'(last_k - first_k), 32'd2);

        // flush with br_pend set and a same-cycle push
        drv(1, 32'h400, 32'h44, 0, 0, 1, 0, 0);
        cycle();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        chk("fl_brpc", D1_FetchPC, 32'h400);
        cycle();
        chk("fl_pend", {31'h0, D1_F2IsBDS}, 32'd1);
        drv(1, 32'h404, 32'h45, 0, 0, 0, 0, 1);
        cycle();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        chk("fl_count", {30'h0, D1_Count}, 32'd0);
        chk("fl_isbds", {31'h0, D1_IsBDS}, 32'd0);
        chk("fl_f2isbds", {31'h0, D1_F2IsBDS}, 32'd0);
        chk("fl_noiss", {31'h0, D1_Issued}, 32'd0);
        cycle();
        cycle();

        // fetch fault
        drv(1, 32'h500, 32'hDEADBEEF, 1, 5'h04, 0, 0, 0);
        cycle();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        chk("flt_instr", D1_Instruction, 32'h0);
        chk("flt_exc", {31'h0, D1_Exception}, 32'd1);
        chk("flt_code", {27'h0, D1_ExcCode}, 32'h04);
        cycle();

        // reset with entries buffered
        drv(1, 32'h600, 32'h60, 0, 0, 0, 1, 0);
        cycle();
        drv(1, 32'h604, 32'h61, 0, 0, 0, 1, 0);
        cycle();
        drv(0, 0, 0, 0, 0, 0, 1, 0);
        chk("mrst_pre", {30'h0, D1_Count}, CAP);
        reset = 1'b0;
        drv(1, 32'h608, 32'h62, 0, 0, 0, 0, 0);
        chk("mrst_rdy", {31'h0, F2_Ready}, 32'd0);
        chk("mrst_iss", {31'h0, D1_Issued}, 32'd0);
        cycle();
        reset = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        chk("mrst_cnt", {30'h0, D1_Count}, 32'd0);
        chk("mrst_iss2", {31'h0, D1_Issued}, 32'd0);
        cycle();

        // randomized traffic; F2 holds each word until accepted
        rv = 1'b0;
        rpc = 32'h0;
        rpc_next = 32'h1000;
        rins = 32'h0;
        re = 1'b0;
        rc = 5'h0;
        rb = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!rv && $urandom_range(0, 99) < 70) begin
                rv = 1'b1;
                rpc = rpc_next;
                rpc_next = rpc_next + 32'd4;
                rins = $urandom;
                re = ($urandom_range(0, 9) == 0);
                rc = 5'($urandom_range(0, 31));
                rb = ($urandom_range(0, 3) == 0);
            end
            reset = ($urandom_range(0, 49) != 0);
            drv(rv, rpc, rins, re, rc, rb,
                $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 5);
            cycle();
            if (m_push) rv = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
